dcache_controller: RTL and testbench

DCACHE_CONTROLLER -- requirements
Module: dcache_controller

---
 rtl/dcache_controller_pkg.sv | 30 +++
 rtl/dcache_sram.sv | 59 +++++
 rtl/dcache_controller.sv | 156 +++++++++++++++
 tb/tb_dcache_controller.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_controller_pkg.sv
// Shared geometry, FSM state encoding and block helpers for the data cache.
package dcache_controller_pkg;

    localparam int TAG_W     = 22;
    localparam int INDEX_W   = 5;
    localparam int BLOCK_W   = 256;
    localparam int WORD_W    = 32;
    localparam int OFFSET_W  = 5;
    localparam int NUM_LINES = 1 << INDEX_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2,
        REFILL    = 2'd3
    } state_e;

    // Replace one 32-bit word of a block, leaving the others untouched.
    function automatic logic [BLOCK_W-1:0] merge_word(
        input logic [BLOCK_W-1:0] blk,
        input logic [2:0]         sel,
        input logic [WORD_W-1:0]  word
    );
        logic [BLOCK_W-1:0] res;
        res = blk;
        res[{sel, 5'b0} +: WORD_W] = word;
        return res;
    endfunction

endpackage

// File: rtl/dcache_sram.sv
// Line storage: valid/dirty bits with async clear, tag and data arrays
// without reset. Read is combinational, write happens on the clock edge.
module dcache_sram
    import dcache_controller_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [INDEX_W-1:0] idx_i,
    input  logic               we_i,
    input  logic               wr_valid_i,
    input  logic               wr_dirty_i,
    input  logic [TAG_W-1:0]   wr_tag_i,
    input  logic [BLOCK_W-1:0] wr_data_i,
    output logic               rd_valid_o,
    output logic               rd_dirty_o,
    output logic [TAG_W-1:0]   rd_tag_o,
    output logic [BLOCK_W-1:0] rd_data_o
);

    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [NUM_LINES-1:0] dirty_q, dirty_d;
    logic [TAG_W-1:0]     tag_mem_q  [NUM_LINES];
    logic [BLOCK_W-1:0]   data_mem_q [NUM_LINES];

    // Next value of the status bits for the addressed line.
    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (we_i) begin
            valid_d[idx_i] = wr_valid_i;
            dirty_d[idx_i] = wr_dirty_i;
        end
    end

    // Status bits are the only storage that reset clears.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tag and data arrays hold whatever was last written, reset or not.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            tag_mem_q[idx_i]  <= wr_tag_i;
            data_mem_q[idx_i] <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_q[idx_i];
    assign rd_dirty_o = dirty_q[idx_i];
    assign rd_tag_o   = tag_mem_q[idx_i];
    assign rd_data_o  = data_mem_q[idx_i];

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate data cache controller.
// Hits complete in zero cycles; misses stall the pipeline while the FSM
// writes back a dirty victim, fetches the new block and refills the line.
module dcache_controller
    import dcache_controller_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [31:0]        p1_addr_i,
    input  logic [31:0]        p1_data_i,
    input  logic               p1_MemRead_i,
    input  logic               p1_MemWrite_i,
    output logic [31:0]        p1_data_o,
    output logic               p1_stall_o,
    input  logic [BLOCK_W-1:0] mem_data_i,
    input  logic               mem_ack_i,
    output logic               mem_enable_o,
    output logic               mem_write_o,
    output logic [31:0]        mem_addr_o,
    output logic [BLOCK_W-1:0] mem_data_o
);

    state_e             state_q, state_d;
    logic               mem_enable_q, mem_enable_d;
    logic               mem_write_q, mem_write_d;
    logic [BLOCK_W-1:0] refill_q, refill_d;

    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] req_idx;
    logic [2:0]         req_word;
    logic               req, is_store, hit;

    logic               line_valid, line_dirty;
    logic [TAG_W-1:0]   line_tag;
    logic [BLOCK_W-1:0] line_data;

    logic               sram_we, wr_valid, wr_dirty;
    logic [TAG_W-1:0]   wr_tag;
    logic [BLOCK_W-1:0] wr_data;

    logic               unused_addr_bits;

    assign req_tag          = p1_addr_i[31:10];
    assign req_idx          = p1_addr_i[9:5];
    assign req_word         = p1_addr_i[4:2];
    assign unused_addr_bits = ^p1_addr_i[1:0];

    // A simultaneous read and write is handled as a store.
    assign req      = p1_MemRead_i | p1_MemWrite_i;
    assign is_store = p1_MemWrite_i;
    assign hit      = req & line_valid & (line_tag == req_tag);

    assign p1_data_o  = line_data[{req_word, 5'b0} +: WORD_W];
    assign p1_stall_o = (req & ~hit) | (state_q != IDLE);

    assign mem_enable_o = mem_enable_q;
    assign mem_write_o  = mem_write_q;
    assign mem_data_o   = line_data;

    // Write-back targets the victim's block; the fetch targets the request's.
    always_comb begin
        if (state_q == WRITEBACK) begin
            mem_addr_o = {line_tag, req_idx, {OFFSET_W{1'b0}}};
        end else begin
            mem_addr_o = {req_tag, req_idx, {OFFSET_W{1'b0}}};
        end
    end

    // Next-state, memory handshake and line-update decisions.
    always_comb begin
        state_d      = state_q;
        mem_enable_d = mem_enable_q;
        mem_write_d  = mem_write_q;
        refill_d     = refill_q;
        sram_we      = 1'b0;
        wr_valid     = 1'b1;
        wr_dirty     = 1'b0;
        wr_tag       = req_tag;
        wr_data      = refill_q;
        case (state_q)
            IDLE: begin
                if (req && !hit) begin
                    mem_enable_d = 1'b1;
                    if (line_valid && line_dirty) begin
                        state_d     = WRITEBACK;
                        mem_write_d = 1'b1;
                    end else begin
                        state_d     = ALLOCATE;
                        mem_write_d = 1'b0;
                    end
                end else if (hit && is_store) begin
                    sram_we  = 1'b1;
                    wr_dirty = 1'b1;
                    wr_data  = merge_word(line_data, req_word, p1_data_i);
                end
            end
            WRITEBACK: begin
                // Request stays asserted straight into the block fetch.
                if (mem_ack_i) begin
                    state_d     = ALLOCATE;
                    mem_write_d = 1'b0;
                end
            end
            ALLOCATE: begin
                if (mem_ack_i) begin
                    state_d      = REFILL;
                    mem_enable_d = 1'b0;
                    refill_d     = mem_data_i;
                end
            end
            REFILL: begin
                sram_we = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d      = IDLE;
                mem_enable_d = 1'b0;
                mem_write_d  = 1'b0;
            end
        endcase
    end

    // Miss FSM with registered memory handshake outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_enable_q <= mem_enable_d;
            mem_write_q  <= mem_write_d;
        end
    end

    // Fetched block waits here for one cycle before it is written to the line.
    always_ff @(posedge clk_i) begin
        refill_q <= refill_d;
    end

    dcache_sram u_sram (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .idx_i      (req_idx),
        .we_i       (sram_we),
        .wr_valid_i (wr_valid),
        .wr_dirty_i (wr_dirty),
        .wr_tag_i   (wr_tag),
        .wr_data_i  (wr_data),
        .rd_valid_o (line_valid),
        .rd_dirty_o (line_dirty),
        .rd_tag_o   (line_tag),
        .rd_data_o  (line_data)
    );

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller with a small behavioural memory.
module tb_dcache_controller;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [31:0]  p1_addr_i;
    logic [31:0]  p1_data_i;
    logic         p1_MemRead_i;
    logic         p1_MemWrite_i;
    logic [31:0]  p1_data_o;
    logic         p1_stall_o;
    logic [255:0] mem_data_i = '0;
    logic         mem_ack_i = 1'b0;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;

    int checks = 0;
    int failures = 0;

    dcache_controller dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .p1_addr_i     (p1_addr_i),
        .p1_data_i     (p1_data_i),
        .p1_MemRead_i  (p1_MemRead_i),
        .p1_MemWrite_i (p1_MemWrite_i),
        .p1_data_o     (p1_data_o),
        .p1_stall_o    (p1_stall_o),
        .mem_data_i    (mem_data_i),
        .mem_ack_i     (mem_ack_i),
        .mem_enable_o  (mem_enable_o),
        .mem_write_o   (mem_write_o),
        .mem_addr_o    (mem_addr_o),
        .mem_data_o    (mem_data_o)
    );

    always #5 clk_i = ~clk_i;

    // ---------------- memory model ----------------
    logic [255:0] mem_blk [logic [31:0]];
    logic [31:0]  log_addr [16];
    logic         log_wr   [16];
    logic [255:0] log_data [16];
    int           n_req = 0;
    int           ack_delay = 3;
    int           cnt = 0;
    logic         spur_ack = 1'b0;

    function automatic logic [255:0] blk_pattern(input logic [31:0] a);
        logic [255:0] b;
        for (int i = 0; i < 8; i++) b[i*32 +: 32] = 32'hA000_0000 | a | i;
        return b;
    endfunction

    function automatic logic [255:0] get_blk(input logic [31:0] a);
        if (mem_blk.exists(a)) return mem_blk[a];
        return blk_pattern(a);
    endfunction

    // Answers each request with an ack pulse in its ack_delay-th cycle.
    always @(negedge clk_i) begin
        logic ack_gen;
        ack_gen = 1'b0;
        if (mem_ack_i) cnt = 0;
        if (mem_enable_o && !rst_i) begin
            cnt++;
            if (cnt == 1 && n_req < 16) begin
                log_addr[n_req] = mem_addr_o;
                log_wr[n_req]   = mem_write_o;
                log_data[n_req] = mem_data_o;
                n_req++;
            end
            if (cnt == ack_delay) begin
                ack_gen = 1'b1;
                if (mem_write_o) mem_blk[mem_addr_o] = mem_data_o;
                else             mem_data_i = get_blk(mem_addr_o);
            end
        end else begin
            cnt = 0;
        end
        if (spur_ack) mem_data_i = '1;
        mem_ack_i = ack_gen | spur_ack;
    end

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Drive one CPU access, count stalled cycles, return the load data.
    task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, output int stalls, output logic [31:0] q);
        logic done;
        p1_MemRead_i  = rd;
        p1_MemWrite_i = wr;
        p1_addr_i     = a;
        p1_data_i     = d;
        stalls = 0;
        done   = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk_i);
            if (!p1_stall_o) done = 1'b1;
            else stalls++;
        end
        chk("access_done", {255'b0, done}, 256'd1);
        q = p1_data_o;
        @(posedge clk_i);
        #1;
        p1_MemRead_i  = 1'b0;
        p1_MemWrite_i = 1'b0;
    endtask

    int           st;
    int           base;
    logic [31:0]  rd;
    logic [255:0] b800;

    initial begin
        b800 = blk_pattern(32'h0000_0800);
        b800[63:32] = 32'hCAFE_F00D;
        mem_blk[32'h0000_0800] = b800;
        mem_blk[32'h0000_0400] = blk_pattern(32'h0000_0400);
        mem_blk[32'h0000_0400][63:32] = 32'hDEAD_BEEF;

        rst_i = 1'b1;
        p1_addr_i = '0;
        p1_data_i = '0;
        p1_MemRead_i = 1'b0;
        p1_MemWrite_i = 1'b0;

        #12;
        chk("rst_enable", {255'b0, mem_enable_o}, 256'd0);
        chk("rst_write", {255'b0, mem_write_o}, 256'd0);
        chk("rst_stall_noreq", {255'b0, p1_stall_o}, 256'd0);
        p1_MemRead_i = 1'b1;
        p1_addr_i = 32'h0000_0404;
        #1;
        chk("rst_stall_req", {255'b0, p1_stall_o}, 256'd1);
        p1_MemRead_i = 1'b0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        // cold miss, clean victim
        base = n_req;
        access(1'b1, 1'b0, 32'h0000_0404, 32'h0, st, rd);
        chk("cold_stalls", 256'(st), 256'd5);
        chk("cold_data", 256'(rd), 256'hDEAD_BEEF);
        chk("cold_nreq", 256'(n_req - base), 256'd1);
        chk("cold_addr", 256'(log_addr[base]), 256'h0000_0400);
        chk("cold_wr", {255'b0, log_wr[base]}, 256'd0);

        // store hit then load hit
        access(1'b0, 1'b1, 32'h0000_0404, 32'h1234_5678, st, rd);
        chk("st_hit_stalls", 256'(st), 256'd0);
        access(1'b1, 1'b0, 32'h0000_0404, 32'h0, st, rd);
        chk("ld_hit_stalls", 256'(st), 256'd0);
        chk("ld_hit_data", 256'(rd), 256'h1234_5678);

        // conflict miss with dirty victim
        base = n_req;
        access(1'b1, 1'b0, 32'h0000_0804, 32'h0, st, rd);
        chk("wb_stalls", 256'(st), 256'd8);
        chk("wb_nreq", 256'(n_req - base), 256'd2);
        chk("wb_wr", {255'b0, log_wr[base]}, 256'd1);
        chk("wb_addr", 256'(log_addr[base]), 256'h0000_0400);
        chk("wb_word1", 256'(log_data[base][63:32]), 256'h1234_5678);
        chk("fetch_wr", {255'b0, log_wr[base+1]}, 256'd0);
        chk("fetch_addr", 256'(log_addr[base+1]), 256'h0000_0800);
        chk("wb_data", 256'(rd), 256'hCAFE_F00D);

        // spurious ack in IDLE
        base = n_req;
        spur_ack = 1'b1;
        @(posedge clk_i);
        #1;
        spur_ack = 1'b0;
        @(negedge clk_i);
        #1;
        chk("spur_stall", {255'b0, p1_stall_o}, 256'd0);
        chk("spur_enable", {255'b0, mem_enable_o}, 256'd0);
        @(posedge clk_i);
        #1;
        access(1'b1, 1'b0, 32'h0000_0804, 32'h0, st, rd);
        chk("spur_hit_stalls", 256'(st), 256'd0);
        chk("spur_hit_data", 256'(rd), 256'hCAFE_F00D);
        chk("spur_nreq", 256'(n_req - base), 256'd0);

        // read+write together on a hit acts as a store and dirties the line
        access(1'b1, 1'b1, 32'h0000_0808, 32'h5555_AAAA, st, rd);
        chk("both_stalls", 256'(st), 256'd0);
        access(1'b1, 1'b0, 32'h0000_0808, 32'h0, st, rd);
        chk("both_ld_stalls", 256'(st), 256'd0);
        chk("both_ld_data", 256'(rd), 256'h5555_AAAA);
        base = n_req;
        access(1'b1, 1'b0, 32'h0000_0008, 32'h0, st, rd);
        chk("evict_stalls", 256'(st), 256'd8);
        chk("evict_wr", {255'b0, log_wr[base]}, 256'd1);
        chk("evict_addr", 256'(log_addr[base]), 256'h0000_0800);
        chk("evict_word2", 256'(log_data[base][95:64]), 256'h5555_AAAA);
        chk("evict_data", 256'(rd), 256'hA000_0002);

        // reset in the middle of ALLOCATE
        ack_delay = 100;
        p1_MemRead_i = 1'b1;
        p1_addr_i = 32'h0000_0404;
        @(negedge clk_i);
        @(negedge clk_i);
        chk("alloc_enable", {255'b0, mem_enable_o}, 256'd1);
        chk("alloc_write", {255'b0, mem_write_o}, 256'd0);
        #2;
        rst_i = 1'b1;
        #1;
        chk("async_rst_enable", {255'b0, mem_enable_o}, 256'd0);
        chk("async_rst_stall", {255'b0, p1_stall_o}, 256'd1);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        ack_delay = 3;
        access(1'b1, 1'b0, 32'h0000_0404, 32'h0, st, rd);
        chk("post_rst_stalls", 256'(st), 256'd5);
        chk("post_rst_data", 256'(rd), 256'h1234_5678);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
